// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a level IRQ.
// Optional prescaler is built when TIMER_PRESCALE_EN is defined.
module timer_dev #(
  parameter int PRESCALE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;
  logic        w_tick;
  logic        w_en, w_reload, w_wr_ctrl, w_wr_preset;

  assign w_en        = r_ctrl[0];
  assign w_reload    = (r_ctrl[2:1] == 2'b01);
  assign w_wr_ctrl   = we && (addr == 2'd0);
  assign w_wr_preset = we && (addr == 2'd1);

  always_ff @(posedge clk)
    assert (PRESCALE >= 1 && PRESCALE <= 65535);

`ifdef TIMER_PRESCALE_EN
  localparam logic [15:0] LP_PRE_LAST = 16'(PRESCALE - 1);
  logic [15:0] r_pre;

  assign w_tick = (r_pre == LP_PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset || r_state != CNT) r_pre <= '0;
    else if (w_tick)             r_pre <= '0;
    else                         r_pre <= r_pre + 16'd1;
  end
`else
  assign w_tick = 1'b1;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_en) w_next = LOAD;
      LOAD: w_next = CNT;
      CNT: begin
        if (!w_en)                          w_next = IDLE;
        else if (w_tick && r_count <= 32'd1) w_next = INT;
      end
      INT:     w_next = w_reload ? LOAD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        LOAD: r_count <= r_preset;
        CNT: begin
          if (w_en && w_tick) begin
            if (r_count > 32'd1) r_count <= r_count - 32'd1;
            else begin
              r_count    <= '0;
              r_irq_flag <= 1'b1;
            end
          end
        end
        INT: begin
          if (w_reload) r_irq_flag <= 1'b0;
          else          r_ctrl[0]  <= 1'b0;
        end
        default: ;
      endcase
      // CPU writes come last so they win over the INT-state EN clear and flag set.
      if (w_wr_ctrl) begin
        r_ctrl     <= wdata[3:0];
        r_irq_flag <= 1'b0;
      end
      if (w_wr_preset) begin
        r_preset   <= wdata;
        r_irq_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (addr)
      2'd0:    rdata = {28'b0, r_ctrl};
      2'd1:    rdata = r_preset;
      2'd2:    rdata = r_count;
      default: rdata = 32'h0;
    endcase
  end

  assign irq = r_ctrl[3] & r_irq_flag;

endmodule
